// File: rtl/gemm_pkg.sv
// gemm_pkg: shared constants, FSM state type and row-major address helper for the GEMM MAC block.
package gemm_pkg;
  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int LW   = $clog2(N);
  localparam int AW   = 2 * LW;
  localparam int ACCW = 2 * DW + LW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // N is a power of two, so r*N+c is plain concatenation.
  function automatic logic [AW-1:0] addr_of(input logic [LW-1:0] r, input logic [LW-1:0] c);
    return {r, c};
  endfunction
endpackage

// File: rtl/gemm_addr_gen.sv
// gemm_addr_gen: p/j/k loop counters, registered A/B read addresses and the
// k-first/k-last tags aligned with the cycle the ROM data is consumed.
module gemm_addr_gen
  import gemm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  output logic [AW-1:0] addr_a1_o,
  output logic [AW-1:0] addr_a2_o,
  output logic [AW-1:0] addr_b_o,
  output logic          last_o,
  output logic          vld_o,
  output logic          k_first_o,
  output logic          k_last_o,
  output logic [LW-1:0] p_o,
  output logic [LW-1:0] j_o
);
  localparam logic [LW-1:0] KMAX = '1;
  localparam logic [LW-1:0] PMAX = LW'(N / 2 - 1);
  localparam logic [LW-1:0] ONE  = LW'(1);

  logic [LW-1:0] p_q, p_d, j_q, j_d, k_q, k_d, p1_q, j1_q;
  logic [AW-1:0] a1_q, a2_q, b_q;
  logic          iss_q, vld_q, kf_q, kl_q;

  always_comb begin
    k_d = load_i ? '0 : adv_i ? k_q + ONE : k_q;
    j_d = load_i ? '0 : (adv_i && k_q == KMAX) ? j_q + ONE : j_q;
    p_d = load_i ? '0 : (adv_i && k_q == KMAX && j_q == KMAX) ? (p_q == PMAX ? '0 : p_q + ONE) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      b_q   <= '0;
      iss_q <= 1'b0;
      vld_q <= 1'b0;
      kf_q  <= 1'b0;
      kl_q  <= 1'b0;
      p1_q  <= '0;
      j1_q  <= '0;
    end else begin
      p_q   <= p_d;
      j_q   <= j_d;
      k_q   <= k_d;
      iss_q <= load_i | adv_i;
      if (load_i | adv_i) begin
        a1_q <= addr_of(p_d << 1, k_d);
        a2_q <= addr_of((p_d << 1) | ONE, k_d);
        b_q  <= addr_of(k_d, j_d);
      end
      // one stage behind issue: matches the registered ROM output
      vld_q <= iss_q;
      kf_q  <= k_q == '0;
      kl_q  <= k_q == KMAX;
      p1_q  <= p_q;
      j1_q  <= j_q;
    end
  end

  assign addr_a1_o = a1_q;
  assign addr_a2_o = a2_q;
  assign addr_b_o  = b_q;
  assign last_o    = p_q == PMAX && j_q == KMAX && k_q == KMAX;
  assign vld_o     = vld_q;
  assign k_first_o = kf_q;
  assign k_last_o  = kl_q;
  assign p_o       = p1_q;
  assign j_o       = j1_q;
endmodule

// File: rtl/gemm_mac_ctrl.sv
// gemm_mac_ctrl: sequences A/B ROM reads and accumulates two Q elements per tile
// (rows 2p and 2p+1), writing each finished pair to the Q RAM.
module gemm_mac_ctrl
  import gemm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          addr_a1,
  output logic [AW-1:0]          addr_a2,
  output logic [AW-1:0]          addr_b,
  input  logic signed [DW-1:0]   a_data1,
  input  logic signed [DW-1:0]   a_data2,
  input  logic signed [DW-1:0]   b_data,
  output logic                   q_we,
  output logic [AW-1:0]          q_addr1,
  output logic [AW-1:0]          q_addr2,
  output logic signed [ACCW-1:0] q_data1,
  output logic signed [ACCW-1:0] q_data2
);
  localparam logic [LW-1:0] ONE = LW'(1);

  state_e                 state_q, state_d;
  logic                   load, adv, last, vld, k_first, k_last;
  logic [LW-1:0]          p_t, j_t;
  logic                   done_q, we_q;
  logic [AW-1:0]          qa1_q, qa2_q;
  logic signed [ACCW-1:0] acc1_q, acc2_q, qd1_q, qd2_q;
  logic signed [ACCW-1:0] prod1, prod2, sum1, sum2;

  gemm_addr_gen u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .adv_i    (adv),
    .addr_a1_o(addr_a1),
    .addr_a2_o(addr_a2),
    .addr_b_o (addr_b),
    .last_o   (last),
    .vld_o    (vld),
    .k_first_o(k_first),
    .k_last_o (k_last),
    .p_o      (p_t),
    .j_o      (j_t)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DRAIN ends once the last product has been folded in and written.
  always_comb begin
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && last)   ? DRAIN :
              (state_q == DRAIN && !vld) ? IDLE : state_q;
  end

  always_comb begin
    load = state_q == IDLE && start;
    adv  = state_q == RUN && !last;
    busy = state_q != IDLE;
  end

  assign prod1 = ACCW'(a_data1) * ACCW'(b_data);
  assign prod2 = ACCW'(a_data2) * ACCW'(b_data);
  assign sum1  = (k_first ? '0 : acc1_q) + prod1;
  assign sum2  = (k_first ? '0 : acc2_q) + prod2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      acc1_q <= '0;
      acc2_q <= '0;
      qd1_q  <= '0;
      qd2_q  <= '0;
      qa1_q  <= '0;
      qa2_q  <= '0;
    end else begin
      done_q <= state_q == DRAIN && !vld;
      we_q   <= vld && k_last;
      if (vld) begin
        acc1_q <= sum1;
        acc2_q <= sum2;
      end
      if (vld && k_last) begin
        qd1_q <= sum1;
        qd2_q <= sum2;
        qa1_q <= addr_of(p_t << 1, j_t);
        qa2_q <= addr_of((p_t << 1) | ONE, j_t);
      end
    end
  end

  assign done    = done_q;
  assign q_we    = we_q;
  assign q_addr1 = qa1_q;
  assign q_addr2 = qa2_q;
  assign q_data1 = qd1_q;
  assign q_data2 = qd2_q;
endmodule

// File: doc/gemm_mac_ctrl.md
Name: gemm_mac_ctrl

Overview:
- Sequencer plus MAC datapath directly downstream of the dual-port A-matrix ROM (RAM_A_2) and the single-port B-matrix ROM.
- Drives their read addresses and consumes their registered 8-bit signed outputs.
- Computes Q = A x B for N x N signed matrices, producing two Q elements per tile (two A rows in parallel), and writes them through a dual write port into the Q RAM.
- start/busy/done handshake to the top-level controller.

Parameters:
- N, 8, matrix dimension; power of two, >= 2.
- DW, 8, signed element width of A and B.
- AW, 6, memory address width = log2(N*N).
- ACCW, 19, signed accumulator/result width = 2*DW + log2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from accept edge until done edge.
- done  out  1  one-cycle pulse after the last Q write.
- addr_a1  out  AW  A read address, port 1 (row 2p).
- addr_a2  out  AW  A read address, port 2 (row 2p+1).
- addr_b  out  AW  B read address.
- a_data1  in  DW  signed A data, port 1; valid 1 cycle after address.
- a_data2  in  DW  signed A data, port 2.
- b_data  in  DW  signed B data.
- q_we  out  1  write strobe for both Q ports.
- q_addr1  out  AW  Q address for row 2p.
- q_addr2  out  AW  Q address for row 2p+1.
- q_data1  out  ACCW  signed result, row 2p.
- q_data2  out  ACCW  signed result, row 2p+1.

Behaviour:
- Reset (async, any state): state IDLE; busy, done, q_we = 0; all addresses, q_addr*, q_data* and accumulators = 0. Pipeline valid tags are cleared, so no write follows reset.
- Storage layout: row-major, element (r,c) at r*N+c, for A, B and Q alike.
- Loops, outermost to innermost:
  - p = 0..N/2-1 (row pair);
  - j = 0..N-1 (column);
  - k = 0..N-1 (dot index).
  - Tile index t = p*N + j.
- Issue, one k per cycle with no bubbles between tiles:
  - addr_a1 = (2p)*N + k
  - addr_a2 = (2p+1)*N + k
  - addr_b = k*N + j
- Addresses are registered. The accept edge E0 loads tile 0, k=0. Tile t, index k is presented after edge E(8t+k).
- States:
  - IDLE: start=1 at an edge -> RUN, busy=1.
  - RUN: after the issue of the last tile, k=N-1 -> DRAIN.
  - DRAIN: waits for the pipeline to empty; at edge E(N*N*N/2+2) (E258 at defaults) -> IDLE, with done=1 for one cycle and busy=0 on that same edge.
  - start outside IDLE is ignored.
- Datapath:
  - ROM data for an address set at E(n) is valid after E(n+1).
  - At E(n+2): acc1 <= (k==0 ? 0 : acc1) + a_data1*b_data, and likewise acc2 with a_data2.
  - Products are DW x DW signed = 2*DW bits, sign-extended to ACCW. No saturation; ACCW is sized so overflow is impossible.
- Write:
  - Edge E(8t+9) registers q_we=1, q_data1/q_data2 = final sums, q_addr1 = (2p)*N + j, q_addr2 = (2p+1)*N + j.
  - q_we is high for exactly one cycle per tile, with consecutive tiles N cycles apart.
  - q_we=0 elsewhere; q_data* hold their last value.
- Latency at defaults:
  - First write at E9.
  - Last write at E257.
  - done at E258.
  - A new start is accepted one cycle after done.
- Address outputs hold their last value in DRAIN and IDLE; ROM reads there are harmless.

Decomposition:
- Package gemm_pkg holds:
  - constants N, DW, AW, ACCW;
  - the state enum {IDLE, RUN, DRAIN};
  - a function computing the address from (row, col).
- One sub-module, gemm_addr_gen, contains:
  - the p/j/k counters, with wrap and carry;
  - address registers;
  - a last-issue flag;
  - k==0 and k==N-1 tags, delayed by 2 cycles, that feed the MAC and write logic.
- The MAC pair and the FSM stay in gemm_mac_ctrl.

Test Plan:
- Bench setup: ROM models with 1-cycle registered reads; a Q RAM model.
- A = ramp (A[r][c] = r*8+c-32), B = identity, start pulsed -> Q equals A bit-for-bit; 32 q_we pulses, the first at E9; done at E258.
- A all -128, B all -128 -> every Q = 131072. A all -128, B all 127 -> every Q = -130048 (checks sign extension and width).
- Random A and B in [-128,127], 3 back-to-back runs, each start issued the cycle after done -> Q matches a golden model; addr_a1/addr_a2/addr_b sequence matches the loop formula every cycle.
- start held high or re-pulsed during RUN at E50 -> ignored; same write count and timing; done pulses exactly once.
- rst_n asserted asynchronously at E100, mid-tile -> all outputs 0 immediately; no q_we afterwards. A fresh start then completes correctly.
- Single-write check at tile t=9 (p=1, j=1) -> q_addr1=17, q_addr2=25, q_we high for exactly the cycle after E81.
